// File: rtl/updown_pkg.sv
// Shared types and default timing constants for the up/down pushbutton controller.
// The state enum is used by the controller FSM; the defaults seed every parameter list.
package updown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_LOCKOUT
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_HOLD_CYCLES     = 20;
    localparam int DEFAULT_REPEAT_CYCLES   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one raw pushbutton.
// The accepted level flips only after the synchronized level disagrees for DEBOUNCE_CYCLES cycles.
module btn_debounce
    import updown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // NOTE: every register here uses <= so the synchronizer stages shift by
    // exactly one flop per edge regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                // Final disagreeing cycle: accept the new level; the >= keeps the count from wrapping.
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_btn_ctrl.sv
// Turns two debounced pushbuttons into count-enable pulses with a direction for a 2-bit
// up/down counter: one step per press, then auto-repeat while held; both buttons lock out.
module updown_btn_ctrl
    import updown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic step,
    output logic UpDown,
    output logic held
);

    localparam int            TW          = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

    logic          up_level;
    logic          down_level;
    logic          active_level;
    logic          other_level;
    logic [TW-1:0] interval_last;
    logic [TW-1:0] timer;
    state_t        state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_up),
        .level (up_level)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_down),
        .level (down_level)
    );

    // UpDown always names the button that produced the last step, so it selects the active one.
    // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        active_level  = UpDown ? up_level   : down_level;
        other_level   = UpDown ? down_level : up_level;
        interval_last = (state == ST_DELAY) ? HOLD_LAST : REPEAT_LAST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            timer  <= '0;
            step   <= 1'b0;
            UpDown <= 1'b0;
            held   <= 1'b0;
        end else begin
            step  <= 1'b0;
            timer <= timer + 1'b1;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (up_level && down_level) begin
                        state <= ST_LOCKOUT;
                    end else if (up_level || down_level) begin
                        state  <= ST_DELAY;
                        step   <= 1'b1;
                        UpDown <= up_level;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    // Conflict beats release, and release beats a timer expiry in the same cycle.
                    if (other_level) begin
                        state <= ST_LOCKOUT;
                        timer <= '0;
                        held  <= 1'b0;
                    end else if (!active_level) begin
                        state <= ST_IDLE;
                        timer <= '0;
                        held  <= 1'b0;
                    end else if (timer == interval_last) begin
                        state <= ST_REPEAT;
                        step  <= 1'b1;
                        timer <= '0;
                        held  <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    timer <= '0;
                    if (!up_level && !down_level) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_btn_ctrl.sv
// Bench for updown_btn_ctrl: directed scenarios with fixed edge expectations plus random
// button activity compared every cycle against an event-time reference model.
module tb_updown_btn_ctrl;

    localparam int DEB = 4;
    localparam int HLD = 20;
    localparam int RPT = 8;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic step;
    logic UpDown;
    logic held;

    int errors = 0;
    int checks = 0;

    updown_btn_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HLD),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .step     (step),
        .UpDown   (UpDown),
        .held     (held)
    );

    always #5 clk = ~clk;

    // Reference model: raw levels delayed two edges, a level accepted after DEB disagreeing
    // cycles, and steps scheduled by absolute cycle number (first after HLD, then every RPT).
    localparam int M_IDLE = 0, M_ACTIVE = 1, M_LOCK = 2;
    logic [1:0] m_s1, m_s2, m_deb;      // bit 1 = up, bit 0 = down
    int         m_run [2];
    int         m_mode;
    longint     m_cyc, m_due;
    logic       m_step, m_ud, m_held;
    bit         mon_en = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 <= '0; m_s2 <= '0; m_deb <= '0;
            m_run[0] <= 0; m_run[1] <= 0;
            m_mode <= M_IDLE; m_cyc <= 0; m_due <= 0;
            m_step <= 1'b0; m_ud <= 1'b0; m_held <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            m_s1  <= {btn_up, btn_down};
            m_s2  <= m_s1;
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    if (m_run[b] + 1 >= DEB) begin
                        m_deb[b] <= m_s2[b];
                        m_run[b] <= 0;
                    end else begin
                        m_run[b] <= m_run[b] + 1;
                    end
                end else begin
                    m_run[b] <= 0;
                end
            end
            m_step <= 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (m_deb == 2'b11) m_mode <= M_LOCK;
                    else if (m_deb != 2'b00) begin
                        m_mode <= M_ACTIVE;
                        m_ud   <= m_deb[1];
                        m_step <= 1'b1;
                        m_due  <= m_cyc + HLD;
                    end
                end
                M_ACTIVE: begin
                    if (m_deb[m_ud ? 0 : 1]) begin
                        m_mode <= M_LOCK; m_held <= 1'b0;
                    end else if (!m_deb[m_ud ? 1 : 0]) begin
                        m_mode <= M_IDLE; m_held <= 1'b0;
                    end else if (m_cyc == m_due) begin
                        m_step <= 1'b1;
                        m_held <= 1'b1;
                        m_due  <= m_cyc + RPT;
                    end
                end
                default: if (m_deb == 2'b00) m_mode <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ({step, UpDown, held} !== {m_step, m_ud, m_held}) begin
                errors++;
                $display("FAIL model_cmp t=%0t step/UpDown/held got=%b%b%b want=%b%b%b",
                         $time, step, UpDown, held, m_step, m_ud, m_held);
            end
        end
    end

    // Scenario bookkeeping: edges counted from the first edge that samples the new raw level.
    int  edge_no;
    int  step_q[$];
    bit  held_seen;
    int  held_first;

    task automatic start_scn();
        edge_no = 0;
        step_q.delete();
        held_seen  = 1'b0;
        held_first = -1;
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            @(posedge clk);
            edge_no++;
            @(negedge clk);
            if (step === 1'b1) step_q.push_back(edge_no);
            if (held === 1'b1 && !held_seen) begin
                held_seen  = 1'b1;
                held_first = edge_no;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({step, UpDown, held} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async got=%b want=000", {step, UpDown, held});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({step, UpDown, held} !== 3'b000) begin
            errors++;
            $display("FAIL reset_clocked got=%b want=000", {step, UpDown, held});
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        advance(10);
    endtask

    task automatic test_tap();
        start_scn();
        btn_up = 1'b1;
        advance(10);
        btn_up = 1'b0;
        advance(20);
        checks++;
        if (step_q.size() != 1 || step_q[0] != DEB + 3) begin
            errors++;
            $display("FAIL tap_steps got_count=%0d first=%0d want_count=1 edge=%0d",
                     step_q.size(), (step_q.size() > 0) ? step_q[0] : -1, DEB + 3);
        end
        checks++;
        if (UpDown !== 1'b1) begin
            errors++;
            $display("FAIL tap_dir got=%b want=1", UpDown);
        end
        checks++;
        if (held_seen) begin
            errors++;
            $display("FAIL tap_held got=held_at_%0d want=never", held_first);
        end
    endtask

    task automatic test_both();
        start_scn();
        btn_up   = 1'b1;
        btn_down = 1'b1;
        advance(15);
        btn_up = 1'b0;
        advance(15);
        btn_down = 1'b0;
        advance(15);
        checks++;
        if (step_q.size() != 0) begin
            errors++;
            $display("FAIL both_lockout got_steps=%0d want=0", step_q.size());
        end
        start_scn();
        btn_down = 1'b1;
        advance(10);
        btn_down = 1'b0;
        advance(20);
        checks++;
        if (step_q.size() != 1 || step_q[0] != 7) begin
            errors++;
            $display("FAIL both_after_tap got_count=%0d first=%0d want_count=1 edge=7",
                     step_q.size(), (step_q.size() > 0) ? step_q[0] : -1);
        end
        checks++;
        if (UpDown !== 1'b0) begin
            errors++;
            $display("FAIL both_after_dir got=%b want=0", UpDown);
        end
    endtask

    task automatic test_bounce();
        start_scn();
        for (int i = 0; i < 6; i++) begin
            btn_down = ~i[0];
            advance(2);
        end
        btn_down = 1'b0;
        advance(30);
        checks++;
        if (step_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_steps got=%0d want=0", step_q.size());
        end
    endtask

    task automatic test_hold();
        int exp_edges [6] = '{7, 27, 35, 43, 51, 59};
        start_scn();
        btn_down = 1'b1;
        advance(56);
        btn_down = 1'b0;
        advance(30);
        checks++;
        if (step_q.size() != 6) begin
            errors++;
            $display("FAIL hold_count got=%0d want=6", step_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= step_q.size() || step_q[i] != exp_edges[i]) begin
                errors++;
                $display("FAIL hold_edge[%0d] got=%0d want=%0d", i,
                         (i < step_q.size()) ? step_q[i] : -1, exp_edges[i]);
            end
        end
        checks++;
        if (held_first != 27) begin
            errors++;
            $display("FAIL hold_held_start got=%0d want=27", held_first);
        end
        checks++;
        if ({UpDown, held} !== 2'b00) begin
            errors++;
            $display("FAIL hold_end UpDown/held got=%b want=00", {UpDown, held});
        end
    endtask

    task automatic test_conflict();
        start_scn();
        btn_up = 1'b1;
        advance(30);
        btn_down = 1'b1;
        advance(20);
        checks++;
        if (step_q.size() != 3 || step_q[2] != 35) begin
            errors++;
            $display("FAIL conflict_steps got_count=%0d last=%0d want_count=3 last=35",
                     step_q.size(), (step_q.size() > 0) ? step_q[step_q.size() - 1] : -1);
        end
        checks++;
        if ({UpDown, held} !== 2'b10) begin
            errors++;
            $display("FAIL conflict_state UpDown/held got=%b want=10", {UpDown, held});
        end
        start_scn();
        btn_up = 1'b0;
        advance(20);
        btn_down = 1'b0;
        advance(20);
        checks++;
        if (step_q.size() != 0) begin
            errors++;
            $display("FAIL conflict_release got_steps=%0d want=0", step_q.size());
        end
    endtask

    task automatic test_async_reset();
        start_scn();
        btn_up = 1'b1;
        advance(35);
        checks++;
        if ({step, held} !== 2'b11) begin
            errors++;
            $display("FAIL areset_pre step/held got=%b want=11", {step, held});
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({step, UpDown, held} !== 3'b000) begin
            errors++;
            $display("FAIL areset_drop got=%b want=000", {step, UpDown, held});
        end
        #1 reset = 1'b0;
        start_scn();
        advance(30);
        checks++;
        if (step_q.size() != 2 || step_q[0] != DEB + 3 || step_q[1] != DEB + 3 + HLD) begin
            errors++;
            $display("FAIL areset_fresh got_count=%0d first=%0d want=2 pulses at %0d,%0d",
                     step_q.size(), (step_q.size() > 0) ? step_q[0] : -1, DEB + 3, DEB + 3 + HLD);
        end
        btn_up = 1'b0;
        advance(20);
    endtask

    task automatic test_random();
        int sel;
        int total_steps;
        total_steps = 0;
        for (int seg = 0; seg < 60; seg++) begin
            sel = $urandom_range(0, 9);
            btn_up   = (sel <= 3) || (sel == 7);
            btn_down = (sel >= 4 && sel <= 7);
            start_scn();
            advance($urandom_range(1, 45));
            total_steps += step_q.size();
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        advance(40);
        checks++;
        if (held !== 1'b0) begin
            errors++;
            $display("FAIL random_idle_held got=%b want=0 (steps seen %0d)", held, total_steps);
        end
    endtask

    initial begin
        test_reset();
        test_tap();
        test_both();
        test_bounce();
        test_hold();
        test_conflict();
        test_async_reset();
        test_random();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
